tea_iter_core: RTL and testbench

- Clocked, iterative successor of the combinational TEA block.
- Encrypts or decrypts one 64-bit block per transaction using a 128-bit key supplied at run time. Round count and rounds-per-clock are parametrised.
- Sits between the host-facing register/bus logic and the data path. Uses valid/ready handshakes on input and output so it can be backpressured.

---
 rtl/tea_iter_core.sv | 175 +++++++++++++++++
 tb/tb_tea_iter_core.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_iter_core.sv
// tea_iter_core: clocked, iterative TEA encrypt/decrypt engine.
// One 64-bit block per transaction, 128-bit run-time key, valid/ready on
// both sides. UNROLL chained rounds are evaluated per clock, so a block
// finishes ROUNDS/UNROLL clocks after it is accepted.
module tea_iter_core #(
  parameter int          ROUNDS = 32,
  parameter int          UNROLL = 1,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] key,
  input  logic [63:0]  data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out,
  output logic         busy,
  output logic [1:0]   status
);

  // Parameter legality is checked while the design is elaborated.
  if (ROUNDS < 1) begin : g_bad_rounds
    $error("tea_iter_core: ROUNDS must be at least 1");
  end
  if ((UNROLL < 1) || ((ROUNDS % UNROLL) != 0)) begin : g_bad_unroll
    $error("tea_iter_core: UNROLL must be >= 1 and divide ROUNDS exactly");
  end

  localparam int                CNT_W    = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0]  ROUNDS_C = CNT_W'(ROUNDS);
  localparam logic [CNT_W-1:0]  UNROLL_C = CNT_W'(UNROLL);
  // Decrypt starts from the sum the encrypt side ends with: DELTA*ROUNDS mod 2^32.
  localparam logic [31:0]       SUM_DEC  = DELTA * 32'(ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // TEA mixing function; all arithmetic wraps modulo 2^32.
  function automatic logic [31:0] tea_f(
    input logic [31:0] x,
    input logic [31:0] s,
    input logic [31:0] ka,
    input logic [31:0] kb
  );
    tea_f = ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  state_t             state_r;
  logic [31:0]        v0_r;
  logic [31:0]        v1_r;
  logic [31:0]        sum_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [127:0]       key_r;
  logic               mode_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [63:0]        data_out_r;
  logic               busy_r;
  logic [1:0]         status_r;

  logic [31:0]        k0_s;
  logic [31:0]        k1_s;
  logic [31:0]        k2_s;
  logic [31:0]        k3_s;
  logic [31:0]        v0_s;
  logic [31:0]        v1_s;
  logic [31:0]        sum_s;
  logic [CNT_W-1:0]   cnt_nxt_s;

  assign k0_s = key_r[127:96];
  assign k1_s = key_r[95:64];
  assign k2_s = key_r[63:32];
  assign k3_s = key_r[31:0];

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign data_out  = data_out_r;
  assign busy      = busy_r;
  assign status    = status_r;

  // Next-state datapath: UNROLL chained encrypt or decrypt rounds.
  always_comb begin
    v0_s      = v0_r;
    v1_s      = v1_r;
    sum_s     = sum_r;
    cnt_nxt_s = cnt_r + UNROLL_C;
    for (int i = 0; i < UNROLL; i++) begin
      if (mode_r == 1'b0) begin
        sum_s = sum_s + DELTA;
        v0_s  = v0_s + tea_f(v1_s, sum_s, k0_s, k1_s);
        v1_s  = v1_s + tea_f(v0_s, sum_s, k2_s, k3_s);
      end else begin
        v1_s  = v1_s - tea_f(v0_s, sum_s, k2_s, k3_s);
        v0_s  = v0_s - tea_f(v1_s, sum_s, k0_s, k1_s);
        sum_s = sum_s - DELTA;
      end
    end
  end

  // Control FSM, working registers and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      v0_r        <= 32'h0;
      v1_r        <= 32'h0;
      sum_r       <= 32'h0;
      cnt_r       <= {CNT_W{1'b0}};
      key_r       <= 128'h0;
      mode_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      data_out_r  <= 64'h0;
      busy_r      <= 1'b0;
      status_r    <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          in_ready_r <= 1'b1;
          if (in_valid && in_ready_r) begin
            v0_r       <= data_in[63:32];
            v1_r       <= data_in[31:0];
            key_r      <= key;
            mode_r     <= mode;
            sum_r      <= mode ? SUM_DEC : 32'h0;
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_RUN;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_RUN: begin
          v0_r  <= v0_s;
          v1_r  <= v1_s;
          sum_r <= sum_s;
          cnt_r <= cnt_nxt_s;
          if (cnt_nxt_s == ROUNDS_C) begin
            data_out_r  <= {v0_s, v1_s};
            out_valid_r <= 1'b1;
            status_r    <= mode_r ? 2'd2 : 2'd1;
            state_r     <= ST_DONE;
          end else begin
            state_r     <= ST_RUN;
          end
        end
        ST_DONE: begin
          // Result is held until the consumer takes it; the next accept
          // can only happen one cycle later, from IDLE.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tea_iter_core.sv
// Bench for tea_iter_core: a default instance (32 rounds, 1 per clock) and
// a 16-round, 4-per-clock instance, checked against a plain TEA model.
module tb_tea_iter_core;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  logic         clk;
  logic         rst;
  logic         in_valid_a;
  logic         in_valid_b;
  logic         mode;
  logic [127:0] key;
  logic [63:0]  data_in;
  logic         out_ready;

  logic         rdy_a, ov_a, busy_a;
  logic [63:0]  dout_a;
  logic [1:0]   st_a;
  logic         rdy_b, ov_b, busy_b;
  logic [63:0]  dout_b;
  logic [1:0]   st_b;

  logic         cur_b;
  logic         c_rdy, c_ov, c_busy;
  logic [63:0]  c_dout;
  logic [1:0]   c_st;

  int errors;
  int checks;

  assign c_rdy  = cur_b ? rdy_b  : rdy_a;
  assign c_ov   = cur_b ? ov_b   : ov_a;
  assign c_busy = cur_b ? busy_b : busy_a;
  assign c_dout = cur_b ? dout_b : dout_a;
  assign c_st   = cur_b ? st_b   : st_a;

  tea_iter_core u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(rdy_a),
    .mode(mode), .key(key), .data_in(data_in), .out_valid(ov_a),
    .out_ready(out_ready), .data_out(dout_a), .busy(busy_a), .status(st_a)
  );

  tea_iter_core #(.ROUNDS(16), .UNROLL(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(rdy_b),
    .mode(mode), .key(key), .data_in(data_in), .out_valid(ov_b),
    .out_ready(out_ready), .data_out(dout_b), .busy(busy_b), .status(st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Textbook TEA: encrypt or decrypt a block with the given round count.
  function automatic logic [63:0] tea_ref(input logic [63:0] d, input logic [127:0] k,
                                          input logic m, input int rounds);
    logic [31:0] y, z, sum, k0, k1, k2, k3;
    y = d[63:32]; z = d[31:0];
    k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
    sum = 32'h0;
    if (!m) begin
      repeat (rounds) begin
        sum = sum + DELTA;
        y = y + (((z << 4) + k0) ^ (z + sum) ^ ((z >> 5) + k1));
        z = z + (((y << 4) + k2) ^ (y + sum) ^ ((y >> 5) + k3));
      end
    end else begin
      repeat (rounds) sum = sum + DELTA;
      repeat (rounds) begin
        z = z - (((y << 4) + k2) ^ (y + sum) ^ ((y >> 5) + k3));
        y = y - (((z << 4) + k0) ^ (z + sum) ^ ((z >> 5) + k1));
        sum = sum - DELTA;
      end
    end
    return {y, z};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected instance, with optional input
  // scrambling during RUN and optional backpressure once the result is up.
  task automatic do_block(input bit sel, input logic m, input logic [127:0] k,
                          input logic [63:0] d, input bit scramble, input int hold,
                          input int exp_lat, output logic [63:0] res);
    int n;
    int lat;
    logic [63:0] held;
    logic [1:0]  hst;
    logic [1:0]  exp_st;
    cur_b = sel;
    exp_st = m ? 2'd2 : 2'd1;
    n = 0;
    while (!c_rdy && n < 100) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_accept", 64'(c_rdy), 64'd1);
    mode = m; key = k; data_in = d;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    chk("busy_after_accept", 64'(c_busy), 64'd1);
    lat = 0;
    while (!c_ov && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (scramble) begin
        mode = $urandom_range(1, 0);
        key = {$urandom, $urandom, $urandom, $urandom};
        data_in = {$urandom, $urandom};
        if (sel) in_valid_b = $urandom_range(1, 0); else in_valid_a = $urandom_range(1, 0);
      end
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("out_valid_up", 64'(c_ov), 64'd1);
    chk("in_ready_in_done", 64'(c_rdy), 64'd0);
    chk("status_done", 64'(c_st), 64'(exp_st));
    res = c_dout;
    held = c_dout;
    hst = c_st;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(c_ov), 64'd1);
      chk("bp_data_out", c_dout, held);
      chk("bp_status", 64'(c_st), 64'(hst));
      chk("bp_in_ready", 64'(c_rdy), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_xfer_out_valid", 64'(c_ov), 64'd0);
    chk("post_xfer_data_kept", c_dout, held);
    chk("post_xfer_status_kept", 64'(c_st), 64'(hst));
    chk("post_xfer_in_ready", 64'(c_rdy), 64'd1);
    chk("post_xfer_busy", 64'(c_busy), 64'd0);
  endtask

  initial begin
    logic [63:0]  r, r2, d;
    logic [127:0] k;
    logic         m;
    logic [63:0]  exp_q [$];
    logic [63:0]  blk_d [3];
    logic [127:0] blk_k [3];
    logic         blk_m [3];
    int issued, got, prev, vcount;
    bit acc, xfer;

    errors = 0; checks = 0; cur_b = 1'b0;
    rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0; mode = 1'b0;
    key = 128'h0; data_in = 64'h0; out_ready = 1'b0;

    // Reset state.
    #1;
    chk("rst_in_ready", 64'(rdy_a), 64'd0);
    chk("rst_out_valid", 64'(ov_a), 64'd0);
    chk("rst_data_out", dout_a, 64'h0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_status", 64'(st_a), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_release", 64'(rdy_a), 64'd1);

    // Known-answer encrypt and decrypt with an all-zero key.
    do_block(1'b0, 1'b0, 128'h0, 64'h0, 1'b0, 0, 32, r);
    chk("kat_encrypt", r, 64'h41EA3A0A_94BAA940);
    do_block(1'b0, 1'b1, 128'h0, 64'h41EA3A0A_94BAA940, 1'b0, 0, 32, r);
    chk("kat_decrypt", r, 64'h0);

    // Round trip with a fixed key, both configurations.
    k = 128'h95A8882C_9D2CC113_815AA0CD_A1C489F7;
    d = 64'h01234567_89ABCDEF;
    do_block(1'b0, 1'b0, k, d, 1'b0, 0, 32, r);
    chk("rt32_encrypt", r, tea_ref(d, k, 1'b0, 32));
    do_block(1'b0, 1'b1, k, r, 1'b0, 0, 32, r2);
    chk("rt32_back", r2, d);
    do_block(1'b1, 1'b0, k, d, 1'b0, 0, 4, r);
    chk("rt16_encrypt", r, tea_ref(d, k, 1'b0, 16));
    do_block(1'b1, 1'b1, k, r, 1'b0, 0, 4, r2);
    chk("rt16_back", r2, d);

    // Random blocks in both directions on both instances.
    for (int i = 0; i < 4; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom};
      m = i[0];
      do_block(1'b0, m, k, d, 1'b0, 0, 32, r);
      chk("rand32", r, tea_ref(d, k, m, 32));
      do_block(1'b1, m, k, d, 1'b0, 0, 4, r);
      chk("rand16", r, tea_ref(d, k, m, 16));
    end

    // Backpressure plus input scrambling while the block is running.
    k = {$urandom, $urandom, $urandom, $urandom};
    d = {$urandom, $urandom};
    do_block(1'b0, 1'b1, k, d, 1'b1, 10, 32, r);
    chk("bp_scramble_result", r, tea_ref(d, k, 1'b1, 32));
    do_block(1'b1, 1'b0, k, d, 1'b1, 10, 4, r);
    chk("bp_scramble_result16", r, tea_ref(d, k, 1'b0, 16));

    // Reset ten clocks into a run aborts the block.
    cur_b = 1'b0;
    mode = 1'b0; key = k; data_in = d;
    in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(ov_a), 64'd0);
    chk("abort_data_out", dout_a, 64'h0);
    chk("abort_status", 64'(st_a), 64'd0);
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_in_ready", 64'(rdy_a), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready_after", 64'(rdy_a), 64'd1);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov_a) vcount++;
    end
    chk("abort_no_out_valid", 64'(vcount), 64'd0);
    d = {$urandom, $urandom};
    do_block(1'b0, 1'b0, k, d, 1'b0, 0, 32, r);
    chk("abort_fresh_block", r, tea_ref(d, k, 1'b0, 32));

    // Streaming: in_valid and out_ready held high for three blocks.
    for (int i = 0; i < 3; i++) begin
      blk_d[i] = {$urandom, $urandom};
      blk_k[i] = {$urandom, $urandom, $urandom, $urandom};
      blk_m[i] = $urandom_range(1, 0);
      exp_q.push_back(tea_ref(blk_d[i], blk_k[i], blk_m[i], 32));
    end
    cur_b = 1'b0;
    issued = 0; got = 0; prev = -1;
    data_in = blk_d[0]; key = blk_k[0]; mode = blk_m[0];
    in_valid_a = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 150; c++) begin
      acc = in_valid_a && rdy_a;
      xfer = ov_a && out_ready;
      if (xfer) begin
        if (got < 3) chk("stream_result", dout_a, exp_q[got]);
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (prev >= 0) chk("stream_spacing", 64'(c - prev), 64'd34);
        prev = c;
        issued++;
        if (issued < 3) begin
          data_in = blk_d[issued]; key = blk_k[issued]; mode = blk_m[issued];
        end else begin
          in_valid_a = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    chk("stream_accepts", 64'(issued), 64'd3);
    chk("stream_results", 64'(got), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
